// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types and defaults for the branch redirect controller.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    BLANK = 2'd2
  } redirect_state_e;

  localparam int unsigned BLANK_CYCLES_DEF = 2;
  localparam int unsigned BLANK_CYCLES_MIN = 1;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// PC-redirect bus between predictor/pipeline (master) and controller (slave).
interface branch_redirect_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall_i;
  logic              pred_valid_i;
  logic [ADDR_W-1:0] pred_target_i;
  logic              corr_valid_i;
  logic [ADDR_W-1:0] corr_target_i;
  logic [ADDR_W-1:0] pc_seq_i;
  logic [ADDR_W-1:0] pc_next_o;
  logic              pc_we_o;
  logic              if_id_flush_o;
  logic              id_ex_flush_o;

  modport master (
    output stall_i, pred_valid_i, pred_target_i, corr_valid_i, corr_target_i, pc_seq_i,
    input  pc_next_o, pc_we_o, if_id_flush_o, id_ex_flush_o
  );

  modport slave (
    input  stall_i, pred_valid_i, pred_target_i, corr_valid_i, corr_target_i, pc_seq_i,
    output pc_next_o, pc_we_o, if_id_flush_o, id_ex_flush_o
  );
endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  // Count up, stick at all-ones, clear on request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clr_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// PC source arbitration: EX correction > IF prediction > sequential PC,
// with stall-deferred predictions and a post-correction blanking window.
module branch_redirect_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BLANK_CYCLES = BLANK_CYCLES_DEF,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  branch_redirect_ctrl_if.slave bus,
  input  logic                  cnt_clr_i,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      mispred_cnt_o,
  output logic [CNT_W-1:0]      redirect_cnt_o
);

  // Illegal settings below the minimum are clamped rather than producing a zero-length window.
  localparam int unsigned BLANK_EFF = (BLANK_CYCLES < BLANK_CYCLES_MIN) ? BLANK_CYCLES_MIN : BLANK_CYCLES;
  localparam int unsigned BW        = $clog2(BLANK_EFF + 1);

  redirect_state_e   state_q, state_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic [BW-1:0]     blank_q, blank_d;
  logic [ADDR_W-1:0] next_pc;
  logic              flush;
  logic              mis_inc;
  logic              red_inc;

  // State, pending target and blank-window register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
      pend_q  <= '0;
      blank_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      blank_q <= blank_d;
    end
  end

  // Next-state, PC select and counter-increment decode.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    blank_d = blank_q;
    next_pc = bus.pc_seq_i;
    flush   = 1'b0;
    mis_inc = 1'b0;
    red_inc = 1'b0;
    if (bus.corr_valid_i) begin
      next_pc = bus.corr_target_i;
      flush   = 1'b1;
      mis_inc = 1'b1;
      state_d = BLANK;
      blank_d = BW'(BLANK_EFF);
      pend_d  = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.pred_valid_i) begin
            if (!bus.stall_i) begin
              next_pc = bus.pred_target_i;
              red_inc = 1'b1;
            end else begin
              pend_d  = bus.pred_target_i;
              state_d = PEND;
            end
          end
        end
        PEND: begin
          next_pc = pend_q;
          if (!bus.stall_i) begin
            red_inc = 1'b1;
            state_d = RUN;
          end
        end
        BLANK: begin
          blank_d = blank_q - BW'(1);
          if (blank_q <= BW'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Outputs are held quiet while reset is asserted.
  always_comb begin
    bus.pc_next_o     = rst_ni ? next_pc : '0;
    bus.pc_we_o       = rst_ni & (bus.corr_valid_i | ~bus.stall_i);
    bus.if_id_flush_o = rst_ni & flush;
    bus.id_ex_flush_o = rst_ni & flush;
    busy_o            = (state_q != RUN);
  end

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (mis_inc),
    .clr_i  (cnt_clr_i),
    .cnt_o  (mispred_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc_i  (red_inc),
    .clr_i  (cnt_clr_i),
    .cnt_o  (redirect_cnt_o)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: driver predicts, monitor compares.
module tb_branch_redirect_ctrl;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int          BLANK  = 2;
  localparam int          CMAX   = 65535;

  typedef struct {
    logic [31:0] next;
    bit          next_care;
    bit          we;
    bit          fl;
    bit          busy;
    logic [15:0] mis;
    logic [15:0] red;
  } exp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              cnt_clr_i = 1'b0;
  logic              busy_o;
  logic [CNT_W-1:0]  mispred_cnt_o;
  logic [CNT_W-1:0]  redirect_cnt_o;

  branch_redirect_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  branch_redirect_ctrl #(.ADDR_W(ADDR_W), .BLANK_CYCLES(BLANK), .CNT_W(CNT_W)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .bus            (bus.slave),
    .cnt_clr_i      (cnt_clr_i),
    .busy_o         (busy_o),
    .mispred_cnt_o  (mispred_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: outstanding deferred prediction and cycles of blanking left.
  logic [31:0] m_pend[$];
  int          m_blank = 0;
  int          m_mis = 0;
  int          m_red = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared mid-cycle, half a period after inputs settle.
  always @(negedge clk_i) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.next_care) chk("pc_next", bus.pc_next_o, e.next);
      chk("pc_we", 32'(bus.pc_we_o), 32'(e.we));
      chk("if_id_flush", 32'(bus.if_id_flush_o), 32'(e.fl));
      chk("id_ex_flush", 32'(bus.id_ex_flush_o), 32'(e.fl));
      chk("busy", 32'(busy_o), 32'(e.busy));
      chk("mispred_cnt", 32'(mispred_cnt_o), 32'(e.mis));
      chk("redirect_cnt", 32'(redirect_cnt_o), 32'(e.red));
    end
  end

  task automatic do_reset();
    exp_t e;
    @(posedge clk_i); #1;
    rst_ni             = 1'b0;
    bus.stall_i        = 1'($urandom);
    bus.pred_valid_i   = 1'($urandom);
    bus.pred_target_i  = $urandom;
    bus.corr_valid_i   = 1'($urandom);
    bus.corr_target_i  = $urandom;
    bus.pc_seq_i       = $urandom;
    cnt_clr_i          = 1'b0;
    e.next = '0; e.next_care = 1; e.we = 0; e.fl = 0; e.busy = 0; e.mis = '0; e.red = '0;
    sb.push_back(e);
    m_pend.delete();
    m_blank = 0;
    m_mis   = 0;
    m_red   = 0;
  endtask

  task automatic step(input bit st, input bit pv, input logic [31:0] pt,
                      input bit cv, input logic [31:0] ct, input logic [31:0] seq,
                      input bit clr);
    exp_t e;
    bit inc_m, inc_r;
    @(posedge clk_i); #1;
    rst_ni            = 1'b1;
    bus.stall_i       = st;
    bus.pred_valid_i  = pv;
    bus.pred_target_i = pt;
    bus.corr_valid_i  = cv;
    bus.corr_target_i = ct;
    bus.pc_seq_i      = seq;
    cnt_clr_i         = clr;
    e.busy = (m_pend.size() != 0) || (m_blank > 0);
    e.mis  = 16'(m_mis);
    e.red  = 16'(m_red);
    e.next_care = 1;
    e.fl   = 0;
    e.we   = cv || !st;
    inc_m  = 0;
    inc_r  = 0;
    if (cv) begin
      e.next = ct;
      e.fl   = 1;
      inc_m  = 1;
      m_pend.delete();
      m_blank = BLANK;
    end else if (m_blank > 0) begin
      e.next = seq;
      m_blank--;
    end else if (m_pend.size() != 0) begin
      if (st) begin
        e.next_care = 0;
      end else begin
        e.next = m_pend.pop_front();
        inc_r  = 1;
      end
    end else if (pv && !st) begin
      e.next = pt;
      inc_r  = 1;
    end else begin
      e.next = seq;
      if (pv) m_pend.push_back(pt);
    end
    sb.push_back(e);
    if (clr) begin
      m_mis = 0;
      m_red = 0;
    end else begin
      if (inc_m && m_mis < CMAX) m_mis++;
      if (inc_r && m_red < CMAX) m_red++;
    end
  endtask

  initial begin
    bus.stall_i = 0; bus.pred_valid_i = 0; bus.pred_target_i = '0;
    bus.corr_valid_i = 0; bus.corr_target_i = '0; bus.pc_seq_i = '0;
    do_reset();
    do_reset();
    // idle after reset
    step(0, 0, 32'h0, 0, 32'h0, 32'h104, 0);
    // unstalled prediction
    step(0, 1, 32'h200, 0, 32'h0, 32'h108, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'h204, 0);
    // prediction under a 3-cycle stall, released afterwards
    step(1, 1, 32'h300, 0, 32'h0, 32'h208, 0);
    step(1, 1, 32'h300, 0, 32'h0, 32'h208, 0);
    step(1, 1, 32'h300, 0, 32'h0, 32'h208, 0);
    step(0, 1, 32'h300, 0, 32'h0, 32'h208, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'h304, 0);
    // correction under stall, then blanked predictions, third accepted
    step(1, 0, 32'h0, 1, 32'h0C4, 32'h308, 0);
    step(0, 1, 32'h500, 0, 32'h0, 32'h0C8, 0);
    step(0, 1, 32'h500, 0, 32'h0, 32'h0CC, 0);
    step(0, 1, 32'h500, 0, 32'h0, 32'h0D0, 0);
    // correction in first blank cycle reloads the window
    step(0, 0, 32'h0, 1, 32'h0C4, 32'h504, 0);
    step(0, 1, 32'h600, 1, 32'h400, 32'h0C8, 0);
    step(0, 1, 32'h600, 0, 32'h0, 32'h404, 0);
    step(1, 1, 32'h600, 0, 32'h0, 32'h408, 0);
    step(0, 1, 32'h700, 0, 32'h0, 32'h408, 0);
    // simultaneous correction and prediction in RUN
    step(0, 1, 32'h800, 1, 32'h900, 32'h704, 0);
    // correction during PEND discards the deferred target
    step(0, 0, 32'h0, 0, 32'h0, 32'h904, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'h908, 0);
    step(1, 1, 32'hA00, 0, 32'h0, 32'h90C, 0);
    step(1, 0, 32'h0, 1, 32'hB00, 32'h90C, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'hB04, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'hB08, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'hB0C, 0);
    // reset mid-PEND
    step(1, 1, 32'hC00, 0, 32'h0, 32'hB10, 0);
    do_reset();
    step(0, 0, 32'h0, 0, 32'h0, 32'h10, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'h14, 0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(3) == 0, $urandom_range(9) < 3, $urandom & 32'hFFFF_FFFC,
             $urandom_range(11) == 0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
             $urandom_range(49) == 0);
      end
    end
    // saturate the misprediction counter
    for (int i = 0; i < CMAX + 5; i++) begin
      step(1'($urandom), 1'($urandom), $urandom, 1, $urandom, $urandom, 0);
    end
    step(0, 0, 32'h0, 1, 32'h40, 32'h44, 1);
    step(0, 0, 32'h0, 0, 32'h0, 32'h48, 0);
    step(0, 0, 32'h0, 0, 32'h0, 32'h4C, 0);
    // drain, bounded
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk_i);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences PC redirection between the branch predictor and the fetch/decode pipeline registers.
- Arbitrates three PC sources:
  - EX-stage misprediction correction (highest priority)
  - IF-stage taken prediction
  - sequential PC (lowest priority)
- Generates IF/ID and ID/EX flushes on correction.
- Defers predictions that arrive under a hazard stall.
- Blanks stale registered predictor outputs for a fixed window after each correction.
- Keeps saturating counters of mispredictions and predicted redirects for performance debug.

Parameters:
- ADDR_W, 32, PC width.
- BLANK_CYCLES, 2, cycles pred_valid_i is ignored after an accepted correction; must be >= 1.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- stall_i  in  1  hazard-unit stall; holds PC and IF/ID.
- pred_valid_i  in  1  predictor signals a taken prediction for the instruction in IF.
- pred_target_i  in  ADDR_W  predicted target.
- corr_valid_i  in  1  predictor signals a misprediction resolved in EX (flush required).
- corr_target_i  in  ADDR_W  correct PC (target, or branch PC+4).
- pc_seq_i  in  ADDR_W  sequential next PC (PC+4).
- cnt_clr_i  in  1  synchronous clear of both counters.
- pc_next_o  out  ADDR_W  PC to load.
- pc_we_o  out  1  PC register load enable.
- if_id_flush_o  out  1  clear IF/ID register.
- id_ex_flush_o  out  1  clear ID/EX register.
- busy_o  out  1  state != RUN.
- mispred_cnt_o  out  CNT_W  accepted corrections, saturating.
- redirect_cnt_o  out  CNT_W  applied predicted redirects, saturating.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=RUN; pending target=0; blank counter=0; both counters=0.
  - pc_we_o=0, flush outputs=0, busy_o=0, pc_next_o=0 while reset is asserted.
- Outputs are combinational from registered state plus current inputs. State, pending target, blank counter and statistics counters update on the rising edge.
- A correction is always accepted the same cycle, in every state, including under stall:
  - pc_next_o=corr_target_i, pc_we_o=1, if_id_flush_o=1, id_ex_flush_o=1.
  - mispred_cnt +1.
  - Next state BLANK, blank counter loaded with BLANK_CYCLES.
  - Any pending prediction is discarded.
- pc_we_o = corr_valid_i | ~stall_i.
- RUN:
  - pred_valid_i & ~stall_i: pc_next_o=pred_target_i; redirect_cnt +1; stay in RUN; no flush.
  - pred_valid_i & stall_i: latch pred_target_i into pending; go to PEND; pc_next_o=pc_seq_i (write is disabled anyway).
  - Otherwise: pc_next_o=pc_seq_i.
- PEND (prediction held behind a stall):
  - stall_i=1: hold the pending target. New pred_valid_i is ignored (same branch is still held in IF).
  - stall_i=0: pc_next_o=pending; redirect_cnt +1; go to RUN.
- BLANK:
  - pred_valid_i is ignored and not counted; pc_next_o=pc_seq_i.
  - The counter decrements every cycle, stall or not.
  - Counter==1 at a clock edge: go to RUN on that edge.
  - A correction in BLANK reloads the counter to BLANK_CYCLES.
- Counters saturate at all-ones and never wrap.
  - cnt_clr_i has priority over an increment in the same cycle; the result is 0.
- A correction and a prediction in the same cycle: the correction wins; the prediction is dropped and not counted.
- Reset mid-PEND or mid-BLANK returns to RUN with no pending redirect.

Decomposition:
- Package branch_ctrl_pkg holds:
  - state enum {RUN, PEND, BLANK} (2 bits)
  - BLANK_CYCLES default
  - localparam for the minimum legal BLANK_CYCLES (1)
- Sub-module sat_counter (CNT_W, inc, clr, async active-low reset), instantiated twice for the statistics counters.

Test Plan:
- Reset release, no requests, stall_i=0, pc_seq_i=0x104 -> pc_next_o=0x104, pc_we_o=1, no flush, busy_o=0, counters 0.
- pred_valid_i=1, pred_target_i=0x200, stall_i=0 -> same-cycle pc_next_o=0x200, no flush, redirect_cnt=1, state stays RUN.
- pred_valid_i=1, target=0x300 with stall_i=1 for 3 cycles -> pc_we_o=0, busy_o=1 (PEND). Stall drops -> pc_next_o=0x300, redirect_cnt +1, busy_o=0 next cycle.
- corr_valid_i=1, corr_target_i=0x0C4 during stall_i=1 -> pc_we_o=1, pc_next_o=0x0C4, both flushes=1, mispred_cnt +1. pred_valid_i held high for the next 2 cycles -> ignored. Third cycle -> accepted.
- Correction in cycle 1 of BLANK (target 0x400) -> counter reloaded, busy_o high for 2 more cycles. Simultaneous pred_valid_i and corr_valid_i -> pc_next_o=corr_target_i, redirect_cnt unchanged.
- Force mispred_cnt to 0xFFFF via repeated corrections -> holds 0xFFFF. cnt_clr_i=1 with corr_valid_i=1 -> counter becomes 0.
